// File: rtl/audio_nios_pio_in_capture_if.sv
// Avalon-MM slave bus for the PIO input-capture port: register select, write strobe/data, zero-wait read data.
// Master drives the request side, slave returns combinational readdata.
interface audio_nios_pio_in_capture_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/audio_nios_pio_in_capture.sv
// Synchronised PIO input with per-bit edge capture (R/W1C), irq mask and level irq; capture lands SYNC_STAGES
// edges after in_port is sampled, reads are zero-wait combinational, no backpressure.
module audio_nios_pio_in_capture #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    audio_nios_pio_in_capture_if.slave avs,
    input  logic [WIDTH-1:0]           in_port,
    output logic                       irq
);
    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int PRIME_W   = $clog2(PRIME_MAX + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  prev_q, prev_d;
    logic [WIDTH-1:0]                  cap_q, cap_d;
    logic [WIDTH-1:0]                  mask_q, mask_d;
    logic [PRIME_W-1:0]                prime_q, prime_d;

    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] rise, fall, edge_sel, clr;
    logic             edge_en;
    logic             wr_en;
    logic             unused_wdata;

    assign sync_val     = sync_q[SYNC_STAGES-1];
    assign wr_en        = avs.chipselect && !avs.write_n;
    assign unused_wdata = ^avs.writedata;

    // The chain and prev hold stale zeros right after reset; edges are masked until they have filled.
    assign edge_en = (prime_q == PRIME_W'(PRIME_MAX));

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], in_port};
        prev_d  = sync_val;
        prime_d = edge_en ? prime_q : prime_q + PRIME_W'(1);

        rise = sync_val & ~prev_q;
        fall = ~sync_val & prev_q;
        case (EDGE_TYPE)
            0:       edge_sel = rise;
            1:       edge_sel = fall;
            default: edge_sel = rise | fall;
        endcase

        mask_d = mask_q;
        clr    = '0;
        if (wr_en && avs.address == 2'd2) mask_d = avs.writedata[WIDTH-1:0];
        if (wr_en && avs.address == 2'd3) clr    = avs.writedata[WIDTH-1:0];

        // A fresh edge beats a simultaneous clear.
        cap_d = (cap_q & ~clr) | (edge_sel & {WIDTH{edge_en}});
    end

    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            2'd0:    avs.readdata[WIDTH-1:0] = sync_val;
            2'd2:    avs.readdata[WIDTH-1:0] = mask_q;
            2'd3:    avs.readdata[WIDTH-1:0] = cap_q;
            default: avs.readdata = '0;
        endcase
    end

    assign irq = |(cap_q & mask_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            prev_q  <= '0;
            cap_q   <= '0;
            mask_q  <= '0;
            prime_q <= '0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cap_q   <= cap_d;
            mask_q  <= mask_d;
            prime_q <= prime_d;
        end
    end
endmodule

// File: tb/tb_audio_nios_pio_in_capture.sv
// Bench: three DUTs (rising, falling, any edge) share clock, reset and in_port and see identical bus traffic;
// a history-based reference model predicts every register read and irq.
module tb_audio_nios_pio_in_capture;
    localparam int W  = 4;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic         irq0, irq1, irq2;

    always #5 clk = ~clk;

    audio_nios_pio_in_capture_if bus0 ();
    audio_nios_pio_in_capture_if bus1 ();
    audio_nios_pio_in_capture_if bus2 ();

    audio_nios_pio_in_capture #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .avs(bus0), .in_port(in_port), .irq(irq0));
    audio_nios_pio_in_capture #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .avs(bus1), .in_port(in_port), .irq(irq1));
    audio_nios_pio_in_capture #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .avs(bus2), .in_port(in_port), .irq(irq2));

    int checks = 0;
    int errors = 0;

    // Reference model: in_port samples taken at each clock edge since reset release.
    logic [W-1:0] hist[$];
    int           n_edges;
    logic [W-1:0] m_cap [3];
    logic [W-1:0] m_mask[3];

    function automatic logic [W-1:0] sync_after(int n);
        int idx;
        idx = n - SS;
        if (idx < 0) return '0;
        return hist[idx];
    endfunction

    function automatic logic [31:0] rd_exp(int et, logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[W-1:0] = sync_after(n_edges);
            2'd2: r[W-1:0] = m_mask[et];
            2'd3: r[W-1:0] = m_cap[et];
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rd_obs(int et);
        case (et)
            0:       return bus0.readdata;
            1:       return bus1.readdata;
            default: return bus2.readdata;
        endcase
    endfunction

    function automatic logic irq_obs(int et);
        case (et)
            0:       return irq0;
            1:       return irq1;
            default: return irq2;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        n_edges = 0;
        for (int et = 0; et < 3; et++) begin
            m_cap[et]  = '0;
            m_mask[et] = '0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic wr, input logic [31:0] d, input logic cs);
        bus0.address = a; bus0.write_n = !wr; bus0.writedata = d; bus0.chipselect = cs;
        bus1.address = a; bus1.write_n = !wr; bus1.writedata = d; bus1.chipselect = cs;
        bus2.address = a; bus2.write_n = !wr; bus2.writedata = d; bus2.chipselect = cs;
    endtask

    // One clock edge; model applies what was driven before the edge.
    task automatic cycle();
        logic         wr;
        logic [1:0]   a;
        logic [31:0]  d;
        logic [W-1:0] ip, s, p, e, clr;
        logic         en;
        wr = bus0.chipselect && !bus0.write_n;
        a  = bus0.address;
        d  = bus0.writedata;
        ip = in_port;
        @(posedge clk);
        if (reset_n) begin
            n_edges++;
            hist.push_back(ip);
            s   = sync_after(n_edges - 1);
            p   = sync_after(n_edges - 2);
            en  = (n_edges >= SS + 2);
            clr = (wr && a == 2'd3) ? d[W-1:0] : '0;
            for (int et = 0; et < 3; et++) begin
                e = (et == 0) ? (s & ~p) : (et == 1) ? (~s & p) : (s ^ p);
                m_cap[et] = (m_cap[et] & ~clr) | (en ? e : '0);
                if (wr && a == 2'd2) m_mask[et] = d[W-1:0];
            end
        end
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        drive(a, 1'b1, d, 1'b1);
        cycle();
        drive(a, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic check_irq(input string tag);
        for (int et = 0; et < 3; et++)
            check($sformatf("%s/et%0d/irq", tag, et), {31'b0, irq_obs(et)}, {31'b0, |(m_cap[et] & m_mask[et])});
    endtask

    // Reads all four addresses on every instance; leaves address at 3.
    task automatic check_point(input string tag);
        check_irq(tag);
        for (int a = 0; a < 4; a++) begin
            drive(2'(a), 1'b0, 32'h0, 1'b1);
            #1;
            for (int et = 0; et < 3; et++)
                check($sformatf("%s/et%0d/a%0d", tag, et, a), rd_obs(et), rd_exp(et, 2'(a)));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        in_port = 4'hF;
        drive(2'd0, 1'b0, 32'h0, 1'b0);
        model_reset();

        // Reset with inputs high, then priming must suppress the startup rise.
        @(negedge clk);
        check_point("rst_hold");
        cycles(2);
        reset_n = 1'b1;
        cycles(10);
        check_point("s1");
        check("s1_cap_lit", bus0.readdata, 32'h0);
        check("s1_irq_lit", {31'b0, irq0}, 32'h0);

        // 0 -> 5: data after k+1, capture after k+2.
        in_port = 4'h0;
        cycles(4);
        write_reg(2'd3, 32'hF);
        check_point("s2_clr");
        in_port = 4'h5;
        cycle();
        check_point("s2_k");
        cycle();
        check_point("s2_k1");
        cycle();
        check_point("s2_k2");
        check("s2_cap_lit", bus0.readdata, 32'h5);
        check("s2_irq_lit", {31'b0, irq0}, 32'h0);

        // Mask enables a captured bit; clear drops irq.
        write_reg(2'd2, 32'h4);
        check_point("s3_mask");
        check("s3_irq_lit", {31'b0, irq0}, 32'h1);
        write_reg(2'd3, 32'h4);
        check_point("s3_clr");
        check("s3_cap_lit", bus0.readdata, 32'h1);
        check("s3_irq0_lit", {31'b0, irq0}, 32'h0);

        // Clear bit0 in the same cycle a new rising edge is captured.
        in_port = 4'h4;
        cycles(3);
        in_port = 4'h5;
        cycles(2);
        write_reg(2'd3, 32'h1);
        check_point("s4_race");
        check("s4_race_lit", bus0.readdata, 32'h1);
        write_reg(2'd3, 32'hF);
        check_point("s4_clr");
        check("s4_clr_lit", bus0.readdata, 32'h0);

        // Edge-type behaviour: bit2 toggles twice, then all bits fall.
        write_reg(2'd3, 32'hF);
        in_port = 4'h1;
        cycles(4);
        check_point("s5_t1");
        check("s5_any_t1_lit", bus2.readdata, 32'h4);
        in_port = 4'h5;
        cycles(4);
        check_point("s5_t2");
        check("s5_any_t2_lit", bus2.readdata, 32'h4);
        in_port = 4'hF;
        cycles(4);
        write_reg(2'd3, 32'hF);
        in_port = 4'h0;
        cycles(4);
        check_point("s5_fall");
        check("s5_fall_lit", bus1.readdata, 32'hF);

        // Randomised traffic, including writes with chipselect low and junk upper writedata bits.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
            if ($urandom_range(0, 1) == 0)
                drive(2'($urandom), 1'b1, $urandom, 1'($urandom));
            else
                drive(2'($urandom), 1'b0, $urandom, 1'b1);
            cycle();
            drive(bus0.address, 1'b0, 32'h0, 1'b1);
            check_irq("rnd");
            if (i % 8 == 7) check_point("rnd");
        end

        // Reset mid-operation with irq high.
        write_reg(2'd2, 32'hF);
        in_port = 4'h0;
        cycles(4);
        write_reg(2'd3, 32'hF);
        in_port = 4'hF;
        cycles(4);
        check_point("s6_pre");
        check("s6_pre_irq_lit", {31'b0, irq0}, 32'h1);
        cycle();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("s6_async_irq0", {31'b0, irq0}, 32'h0);
        check("s6_async_irq1", {31'b0, irq1}, 32'h0);
        check("s6_async_irq2", {31'b0, irq2}, 32'h0);
        check("s6_async_cap", bus0.readdata, 32'h0);
        @(negedge clk);
        check_point("s6_in_rst");
        cycles(2);
        reset_n = 1'b1;
        cycles(10);
        check_point("s6_post");
        in_port = 4'h0;
        cycles(4);
        in_port = 4'hF;
        cycles(4);
        check_point("s6_fresh");
        write_reg(2'd2, 32'hF);
        check_point("s6_mask");
        check("s6_irq_lit", {31'b0, irq0}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
